vga_scanout: RTL

VGA_SCANOUT -- requirements
Module: vga_scanout

---
 rtl/vga_scanout.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/vga_scanout.sv
// vga_scanout: VGA raster timing with a small pixel FIFO.
// An empty FIFO at a visible pixel blanks the rest of the frame until resync.
module vga_scanout #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk50,
  input  logic        rstn50,
  input  logic        pix_valid,
  input  logic [11:0] pix_data,
  output logic        pix_ready,
  output logic        frame_start,
  input  logic        clear_underflow,
  output logic        underflow,
  output logic [3:0]  VGA_r,
  output logic [3:0]  VGA_g,
  output logic [3:0]  VGA_b,
  output logic        VGA_hsync,
  output logic        VGA_vsync
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [AW:0]   FULL   = (AW+1)'(FIFO_DEPTH);

  logic          tick;
  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          resync;
  logic          ready_en;
  logic [11:0]   rgb;
  logic [11:0]   mem [FIFO_DEPTH];

  logic active;
  logic empty;
  logic full;
  logic pop;
  logic push;
  logic uf_ev;

  assign active = (hcnt < H_ACT) && (vcnt < V_ACT);
  assign empty  = (count == '0);
  assign full   = (count == FULL);

  // Start of vertical back porch: upstream rewinds to pixel (0,0).
  assign frame_start = tick && (hcnt == '0) && (vcnt == VS_END);

  assign pop   = tick && active && !resync && !empty;
  assign uf_ev = tick && active && !resync && empty;

  assign pix_ready = ready_en && !frame_start && (resync || !full);
  assign push      = pix_valid && pix_ready && !resync;

  assign VGA_r = rgb[11:8];
  assign VGA_g = rgb[7:4];
  assign VGA_b = rgb[3:0];

  always_ff @(posedge clk50 or negedge rstn50) begin
    if (!rstn50) begin
      tick      <= 1'b0;
      ready_en  <= 1'b0;
      hcnt      <= '0;
      vcnt      <= '0;
      rgb       <= '0;
      VGA_hsync <= 1'b1;
      VGA_vsync <= 1'b1;
    end else begin
      tick     <= ~tick;
      ready_en <= 1'b1;
      if (tick) begin
        hcnt <= (hcnt == H_LAST) ? '0 : hcnt + 1'b1;
        if (hcnt == H_LAST) begin
          vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
        end
        rgb       <= pop ? mem[rd_ptr] : '0;
        VGA_hsync <= !((hcnt >= HS_BEG) && (hcnt < HS_END));
        VGA_vsync <= !((vcnt >= VS_BEG) && (vcnt < VS_END));
      end
    end
  end

  always_ff @(posedge clk50 or negedge rstn50) begin
    if (!rstn50) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (frame_start) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk50) begin
    if (push) mem[wr_ptr] <= pix_data;
  end

  // A fresh underflow beats a simultaneous clear.
  always_ff @(posedge clk50 or negedge rstn50) begin
    if (!rstn50) begin
      resync    <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (frame_start)  resync <= 1'b0;
      else if (uf_ev)   resync <= 1'b1;
      if (uf_ev)                underflow <= 1'b1;
      else if (clear_underflow) underflow <= 1'b0;
    end
  end

endmodule
